// File: rtl/tdm_mux_pkg.sv
// ============================================================================
// Module : tdm_mux_pkg
// Brief  : Shared mode encodings and output-stage state type for tdm_mux.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package tdm_mux_pkg;

    localparam logic TDM_MODE_FIXED = 1'b0;
    localparam logic TDM_MODE_RR    = 1'b1;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

endpackage

`default_nettype wire

// File: rtl/tdm_mux_if.sv
// ============================================================================
// Module : tdm_mux_if
// Brief  : Channel-input / shared-output bundle for tdm_mux.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface tdm_mux_if #(
    parameter int W  = 14,
    parameter int N  = 4,
    parameter int SW = 2
) ();
    logic [N*W-1:0] d;
    logic [N-1:0]   dv;
    logic           mode;
    logic [SW-1:0]  s;
    logic [W-1:0]   y;
    logic [SW-1:0]  ych;
    logic           yv;
    logic           yrdy;
    logic           clr;
    logic [N-1:0]   ovf;

    modport master (output d, dv, mode, s, yrdy, clr,
                    input  y, ych, yv, ovf);
    modport slave  (input  d, dv, mode, s, yrdy, clr,
                    output y, ych, yv, ovf);
endinterface

`default_nettype wire

// File: rtl/tdm_mux_rr_pick.sv
// ============================================================================
// Module : tdm_rr_pick
// Brief  : Combinational round-robin search: first request at or after start.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tdm_rr_pick #(
    parameter int N  = 4,
    parameter int SW = 2
) (
    input  wire logic [N-1:0]  i_req,
    input  wire logic [SW-1:0] i_start,
    output logic               o_gnt_vld,
    output logic [SW-1:0]      o_idx
);

    logic [SW:0] w_j;

    // Walk offsets from far to near so the nearest request is written last.
    always_comb begin
        o_gnt_vld = 1'b0;
        o_idx     = '0;
        w_j       = '0;
        for (int off = N - 1; off >= 0; off--) begin
            w_j = {1'b0, i_start} + (SW+1)'(off);
            if (w_j >= (SW+1)'(N)) begin
                w_j = w_j - (SW+1)'(N);
            end
            if (i_req[w_j[SW-1:0]]) begin
                o_gnt_vld = 1'b1;
                o_idx     = w_j[SW-1:0];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/tdm_mux.sv
// ============================================================================
// Module : tdm_mux
// Brief  : Registered N-channel TDM multiplexer, round-robin or fixed drain.
//          Overrun flags built only when TDM_MUX_OVF_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tdm_mux
    import tdm_mux_pkg::*;
#(
    parameter int W  = 14,
    parameter int N  = 4,
    parameter int SW = 2
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    tdm_mux_if.slave   bus
);

    logic [W-1:0]  r_h [N];
    logic [N-1:0]  r_p;
    logic [SW-1:0] r_ptr;
    logic [W-1:0]  r_y;
    logic [SW-1:0] r_ych;
    out_state_e    r_state;
    out_state_e    w_state_nxt;

    logic [N-1:0]  w_keep;
    logic [N-1:0]  w_req;
    logic [N-1:0]  w_drain;
    logic [N-1:0]  w_ovr;
    logic [N-1:0]  w_p_nxt;
    logic [SW-1:0] w_k;
    logic [SW-1:0] w_ptr_inc;
    logic          w_gnt;
    logic          w_load_ok;
    logic          w_load;
    logic          w_s_ok;

    assign w_s_ok = ({1'b0, bus.s} < (SW+1)'(N));

    // In fixed mode only channel S keeps its pending bit; others are flushed.
    for (genvar i = 0; i < N; i++) begin : g_ch
        assign w_keep[i]  = (bus.mode == TDM_MODE_RR) || (w_s_ok && (bus.s == SW'(i)));
        assign w_req[i]   = r_p[i] && w_keep[i];
        assign w_drain[i] = w_load && (w_k == SW'(i));
        assign w_ovr[i]   = w_keep[i] && bus.dv[i] && r_p[i] && !w_drain[i];
        assign w_p_nxt[i] = w_keep[i] && (bus.dv[i] || (r_p[i] && !w_drain[i]));
    end

    tdm_rr_pick #(.N(N), .SW(SW)) u_pick (
        .i_req     (w_req),
        .i_start   (r_ptr),
        .o_gnt_vld (w_gnt),
        .o_idx     (w_k)
    );

    assign w_ptr_inc = (w_k == SW'(N - 1)) ? '0 : w_k + SW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load_ok   = (r_state == ST_EMPTY) || bus.yrdy;
        w_load      = w_load_ok && w_gnt;
        if (w_load_ok) begin
            w_state_nxt = w_gnt ? ST_FULL : ST_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                r_h[i] <= '0;
            end
            r_p   <= '0;
            r_ptr <= '0;
            r_y   <= '0;
            r_ych <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (bus.dv[i]) begin
                    r_h[i] <= bus.d[i*W +: W];
                end
            end
            r_p <= w_p_nxt;
            // Output takes the pre-capture holding value on a collision.
            if (w_load) begin
                r_y   <= r_h[w_k];
                r_ych <= w_k;
                if (bus.mode == TDM_MODE_RR) begin
                    r_ptr <= w_ptr_inc;
                end
            end
        end
    end

    assign bus.y   = r_y;
    assign bus.ych = r_ych;
    assign bus.yv  = (r_state == ST_FULL);

`ifdef TDM_MUX_OVF_EN
    logic [N-1:0] r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= '0;
        end else begin
            r_ovf <= (r_ovf & ~{N{bus.clr}}) | w_ovr;
        end
    end

    assign bus.ovf = r_ovf;
`else
    assign bus.ovf = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_tdm_mux.sv
// ============================================================================
// Module : tb_tdm_mux
// Brief  : Directed self-checking bench for tdm_mux (N=4, W=14).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_tdm_mux;
    import tdm_mux_pkg::*;

    localparam int W  = 14;
    localparam int N  = 4;
    localparam int SW = 2;
`ifdef TDM_MUX_OVF_EN
    localparam bit c_OVF_ON = 1'b1;
`else
    localparam bit c_OVF_ON = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    tdm_mux_if #(.W(W), .N(N), .SW(SW)) bus ();

    tdm_mux #(.W(W), .N(N), .SW(SW)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input int ch, input logic [W-1:0] val);
        bus.d[ch*W +: W] = val;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        bus.d    = '0;
        bus.dv   = '0;
        bus.mode = TDM_MODE_RR;
        bus.s    = '0;
        bus.yrdy = 1'b1;
        bus.clr  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_y",   32'(bus.y),   32'h0);
        chk("rst_ych", 32'(bus.ych), 32'h0);
        chk("rst_yv",  32'(bus.yv),  32'h0);
        chk("rst_ovf", 32'(bus.ovf), 32'h0);
        @(negedge clk) rst_n = 1'b1;

        // Round-robin order after a simultaneous burst on all channels
        for (int i = 0; i < N; i++) set_d(i, W'(i + 1));
        bus.dv = 4'b1111;
        tick();
        chk("rr_lat_yv", 32'(bus.yv), 32'h0);
        bus.dv = '0;
        for (int c = 0; c < N; c++) begin
            tick();
            chk("rr_yv",  32'(bus.yv),  32'h1);
            chk("rr_ych", 32'(bus.ych), 32'(c));
            chk("rr_y",   32'(bus.y),   32'(c + 1));
        end
        tick();
        chk("rr_end_yv", 32'(bus.yv), 32'h0);
        chk("rr_end_y",  32'(bus.y),  32'h4);

        // Backpressure with an overrun on channel 2
        set_d(0, 14'h0AA);
        bus.dv = 4'b0001;
        tick();
        bus.dv = '0;
        tick();
        chk("bp_y0", 32'(bus.y), 32'h0AA);
        bus.yrdy = 1'b0;
        set_d(2, 14'h111);
        bus.dv = 4'b0100;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (c == 0) set_d(2, 14'h222);
            if (c == 1) bus.dv = '0;
            chk("bp_hold_y",   32'(bus.y),   32'h0AA);
            chk("bp_hold_ych", 32'(bus.ych), 32'h0);
            chk("bp_hold_yv",  32'(bus.yv),  32'h1);
        end
        chk("bp_ovf", 32'(bus.ovf), c_OVF_ON ? 32'h4 : 32'h0);
        bus.yrdy = 1'b1;
        tick();
        chk("bp_y_new", 32'(bus.y),   32'h222);
        chk("bp_ych",   32'(bus.ych), 32'h2);
        tick();
        chk("bp_end_yv", 32'(bus.yv), 32'h0);

        // Clear racing a new overrun on channel 1: set wins
        bus.yrdy = 1'b0;
        set_d(0, 14'h005);
        bus.dv = 4'b0001;
        tick();
        set_d(1, 14'h010);
        bus.dv = 4'b0010;
        tick();
        chk("clr_y0", 32'(bus.y), 32'h005);
        set_d(1, 14'h020);
        bus.clr = 1'b1;
        tick();
        chk("clr_ovf", 32'(bus.ovf), c_OVF_ON ? 32'h2 : 32'h0);
        bus.clr  = 1'b0;
        bus.dv   = '0;
        bus.yrdy = 1'b1;
        tick();
        chk("clr_y1",   32'(bus.y),   32'h020);
        chk("clr_ych1", 32'(bus.ych), 32'h1);
        tick();
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        chk("clr_all", 32'(bus.ovf), 32'h0);

        // Fixed mode on channel 1 with all channels streaming
        bus.mode = TDM_MODE_FIXED;
        bus.s    = 2'd1;
        for (int c = 1; c <= 6; c++) begin
            for (int i = 0; i < N; i++) set_d(i, W'(16 * c + i));
            bus.dv = 4'b1111;
            tick();
            if (c == 1) begin
                chk("fx_first_yv", 32'(bus.yv), 32'h0);
            end else begin
                chk("fx_yv",  32'(bus.yv),  32'h1);
                chk("fx_ych", 32'(bus.ych), 32'h1);
                chk("fx_y",   32'(bus.y),   32'(16 * (c - 1) + 1));
            end
            chk("fx_ovf", 32'(bus.ovf), 32'h0);
        end
        bus.dv = '0;
        bus.s  = 2'd3;
        bus.s  = SW'(7);
        tick();
        chk("fx_bad_s_yv", 32'(bus.yv), 32'h0);

        // Drain/capture collision on a single active channel
        bus.mode = TDM_MODE_RR;
        for (int c = 1; c <= 6; c++) begin
            set_d(3, W'(32'h100 + c));
            bus.dv = 4'b1000;
            tick();
            if (c == 1) begin
                chk("col_first_yv", 32'(bus.yv), 32'h0);
            end else begin
                chk("col_yv",  32'(bus.yv),  32'h1);
                chk("col_ych", 32'(bus.ych), 32'h3);
                chk("col_y",   32'(bus.y),   32'h100 + 32'(c - 1));
            end
        end
        bus.dv = '0;
        tick();
        chk("col_last_y", 32'(bus.y), 32'h106);
        tick();
        chk("col_end_yv", 32'(bus.yv), 32'h0);
        chk("col_ovf",    32'(bus.ovf), 32'h0);

        // Asynchronous reset while the output holds a sample
        set_d(2, 14'h155);
        bus.dv = 4'b0100;
        tick();
        bus.dv = '0;
        tick();
        chk("ar_pre_y", 32'(bus.y), 32'h155);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_y",   32'(bus.y),   32'h0);
        chk("ar_yv",  32'(bus.yv),  32'h0);
        chk("ar_ych", 32'(bus.ych), 32'h0);
        chk("ar_ovf", 32'(bus.ovf), 32'h0);
        @(negedge clk) rst_n = 1'b1;
        set_d(0, 14'h3FFF);
        bus.dv = 4'b0001;
        tick();
        bus.dv = '0;
        tick();
        chk("ar_post_y",   32'(bus.y),   32'h3FFF);
        chk("ar_post_yv",  32'(bus.yv),  32'h1);
        chk("ar_post_ych", 32'(bus.ych), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
